muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide engine and its sequencing controller, attached to the EX stage beside the ALU.
- Accepts one M-extension operation per handshake, runs a shift-add or restoring-divide loop, and returns a registered result with a one-cycle done pulse.
- Drives busy so the hazard/stall logic freezes IF/ID/EX while an operation is in flight.

---
 rtl/muldiv_unit_pkg.sv | 46 ++++
 rtl/muldiv_unit_if.sv | 21 ++
 rtl/muldiv_unit_negate.sv | 21 ++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit.
// Holds the funct3 codes, the OP/M-extension encodings and the controller state type.
package muldiv_unit_pkg;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is signed for every op except MULHU, DIVU and REMU
    function automatic logic f3_a_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(parameter int XLEN = 32) ();
    logic            valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output valid, funct3, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  valid, funct3, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit_negate.sv
// Parameterised two's-complement conditional negator, used for operand
// magnitudes and for the final sign correction.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    // Negate when requested, otherwise pass through
    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + {{(W-1){1'b0}}, 1'b1};
        end else begin
            o_val = i_val;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, with a registered result, one-cycle done pulse and busy stall.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_special;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_spec_res;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;
    logic                r_busy;
    logic                r_done;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_special;
    logic [XLEN-1:0]     w_spec_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fin_res;

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    assign w_a_neg = f3_a_signed(bus.funct3) & bus.rs1[XLEN-1];
    assign w_b_neg = f3_b_signed(bus.funct3) & bus.rs2[XLEN-1];

    muldiv_negate #(.W(XLEN)) u_abs_a (.i_val(bus.rs1), .i_neg(w_a_neg), .o_val(w_abs_a));
    muldiv_negate #(.W(XLEN)) u_abs_b (.i_val(bus.rs2), .i_neg(w_b_neg), .o_val(w_abs_b));

    // Divide-by-zero and signed overflow bypass the loop with a fixed answer
    always_comb begin
        w_special  = 1'b0;
        w_spec_res = '0;
        if (f3_is_div(bus.funct3) && (bus.rs2 == '0)) begin
            w_special  = 1'b1;
            w_spec_res = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_DIVU)) ? '1 : bus.rs1;
        end else if (((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                     (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1)) begin
            w_special  = 1'b1;
            w_spec_res = (bus.funct3 == F3_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end else begin
            w_special  = 1'b0;
            w_spec_res = '0;
        end
    end

    // Multiply: acc = {partial_hi, multiplier}; add multiplicand on LSB then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; keep the subtraction only if it does not borrow
    assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_next  = w_div_diff[XLEN]
                       ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

    muldiv_negate #(.W(2*XLEN)) u_neg_prod (.i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
    muldiv_negate #(.W(XLEN))   u_neg_quot (.i_val(r_acc[XLEN-1:0]), .i_neg(r_neg_q), .o_val(w_quot));
    muldiv_negate #(.W(XLEN))   u_neg_rem  (.i_val(r_acc[2*XLEN-1:XLEN]), .i_neg(r_neg_r), .o_val(w_rem));

    // Select the sign-corrected half that the latched op returns
    always_comb begin
        w_fin_res = '0;
        case (r_op)
            F3_MUL:                       w_fin_res = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fin_res = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_fin_res = w_quot;
            F3_REM, F3_REMU:              w_fin_res = w_rem;
            default:                      w_fin_res = '0;
        endcase
    end

    // Controller FSM with iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= 3'b000;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_b        <= '0;
            r_spec_res <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid && !bus.flush) begin
                        r_op       <= bus.funct3;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_b        <= f3_is_div(bus.funct3) ? w_abs_b : w_abs_a;
                        r_acc      <= {{XLEN{1'b0}}, (f3_is_div(bus.funct3) ? w_abs_a : w_abs_b)};
                        r_state    <= w_special ? ST_FIN : ST_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= f3_is_div(r_op) ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (!bus.flush) begin
                        r_result <= r_special ? r_spec_res : w_fin_res;
                        r_done   <= 1'b1;
                    end else begin
                        r_done   <= 1'b0;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, special
// divide cases, flush, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcyc, output logic [31:0] res);
        @(negedge clk);
        bus.valid = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        lat = 0; bcyc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [4] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
        logic [31:0] as  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat, bcyc;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, bcyc, res);
            n_tests++; if (res !== exp[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_tests++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
            n_tests++; if (bcyc != 33) begin n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected 33", i, bcyc); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat, bcyc;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, bcyc, res);
            n_tests++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_tests++; if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s [4] = '{F3_DIV, F3_REM, F3_DIV, F3_REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat, bcyc;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], lat, bcyc, res);
            n_tests++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_tests++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
            n_tests++; if (bcyc != 1) begin n_fail++; $display("FAIL special_busy_cycles[%0d]: got %0d expected 1", i, bcyc); end
        end
    endtask

    task automatic test_flush();
        int lat, bcyc;
        logic [31:0] res;
        bit seen_done;
        run_op(F3_MUL, 32'd3, 32'd5, lat, bcyc, res);
        n_tests++; if (res !== 32'd15) begin n_fail++; $display("FAIL flush_prior_result: got %h expected %h", res, 32'd15); end
        @(negedge clk);
        bus.valid = 1'b1; bus.funct3 = F3_DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.result !== 32'd15) begin n_fail++; $display("FAIL flush_result_kept: got %h expected %h", bus.result, 32'd15); end
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", seen_done); end
        run_op(F3_MUL, 32'd3, 32'd4, lat, bcyc, res);
        n_tests++; if (res !== 32'd12) begin n_fail++; $display("FAIL flush_next_mul: got %h expected %h", res, 32'd12); end
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL flush_next_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.valid = 1'b1; bus.funct3 = F3_MUL; bus.rs1 = 32'd6; bus.rs2 = 32'd7;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h expected 00000000", bus.result); end
    endtask

    task automatic test_back_to_back();
        int k, dones, consec;
        logic prev_done;
        logic [31:0] last_res;
        @(negedge clk);
        bus.valid = 1'b1; bus.funct3 = F3_MUL; bus.rs1 = 32'd2; bus.rs2 = 32'd3;
        @(posedge clk); #1;
        k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++; if (bus.result !== 32'd6) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", bus.result, 32'd6); end
        n_tests++; if (k != 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 33", k); end
        bus.rs1 = 32'd5; bus.rs2 = 32'd5;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy: got %b expected 1", bus.busy); end
        dones = 1; consec = 0; prev_done = 1'b0; last_res = 32'h0;
        for (int c = 0; c < 80; c++) begin
            if (bus.done) begin
                dones++;
                last_res = bus.result;
                if (prev_done) consec++;
            end
            prev_done = bus.done;
            @(posedge clk); #1;
        end
        n_tests++; if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        n_tests++; if (last_res !== 32'd25) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", last_res, 32'd25); end
        n_tests++; if (consec != 0) begin n_fail++; $display("FAIL b2b_done_consecutive: got %0d expected 0", consec); end
    endtask

    initial begin
        bus.valid  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = 32'h0;
        bus.rs2    = 32'h0;
        bus.flush  = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
